word_byte_serializer: RTL and testbench

- Sequences a 32-bit word into a stream of bytes, one byte per accepted output transfer, using the same byte lanes as the word splitter: lane 1 = [31:24], lane 2 = [23:16], lane 3 = [15:8], lane 4 = [7:0].
- Sits between a word-wide producer (register file or memory read port) and a byte-wide consumer (UART/display/byte bus).
- Provides valid/ready handshakes on both sides, a configurable byte count and lane order per word, and zero-bubble back-to-back operation.

---
 rtl/word_byte_serializer.sv | 128 ++++++++++++
 tb/tb_word_byte_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: turns one accepted 32-bit word into 1..4 byte
// transfers, MSB-lane or LSB-lane first, with no bubble between words.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_ready      word-side handshake
//   in_data, in_len,       word, byte count minus 1, lane order
//   in_lsb_first           (all latched on accept)
//   out_valid/out_ready    byte-side handshake
//   out_byte, out_last     current byte, final byte of its word
//   busy                   a word is held
//   words_done             completed-word counter, wraps
module word_byte_serializer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_len,
    input  logic             in_lsb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state_q, state_nx;
    logic [31:0]      hold_q, hold_nx;
    logic [1:0]       len_q, len_nx;
    logic             lsb_q, lsb_nx;
    logic [1:0]       idx_q, idx_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    logic             in_acc;
    logic             out_xfer;
    logic [1:0]       lane;

    // lane 0 is [31:24]; LSB-first walks the lanes from the bottom up
    assign lane = lsb_q ? (2'd3 - idx_q) : idx_q;

    always_comb begin
        unique case (lane)
            2'd0:    out_byte = hold_q[31:24];
            2'd1:    out_byte = hold_q[23:16];
            2'd2:    out_byte = hold_q[15:8];
            default: out_byte = hold_q[7:0];
        endcase
    end

    assign out_valid  = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign out_last   = (state_q == SEND) && (idx_q == len_q);
    assign words_done = cnt_q;

    // a new word may enter while the last byte of the old one leaves
    assign in_ready = !reset &&
                      ((state_q == IDLE) || (out_ready && out_last));

    assign in_acc   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_nx = state_q;
        hold_nx  = hold_q;
        len_nx   = len_q;
        lsb_nx   = lsb_q;
        idx_nx   = idx_q;
        cnt_nx   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    hold_nx  = in_data;
                    len_nx   = in_len;
                    lsb_nx   = in_lsb_first;
                    idx_nx   = 2'd0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (out_xfer) begin
                    if (out_last) begin
                        cnt_nx   = cnt_q + CNT_W'(1);
                        state_nx = IDLE;
                        if (in_acc) begin
                            hold_nx  = in_data;
                            len_nx   = in_len;
                            lsb_nx   = in_lsb_first;
                            idx_nx   = 2'd0;
                            state_nx = SEND;
                        end
                    end else begin
                        idx_nx = idx_q + 2'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= 32'h0;
            len_q   <= 2'd0;
            lsb_q   <= 1'b0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            hold_q  <= hold_nx;
            len_q   <= len_nx;
            lsb_q   <= lsb_nx;
            idx_q   <= idx_nx;
            cnt_q   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Testbench for word_byte_serializer: directed scenarios plus random
// traffic against a queue-of-bytes reference model.
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        in_lsb_first;
    logic        out_ready;

    logic        in_ready, out_valid, out_last, busy;
    logic [7:0]  out_byte;
    logic [15:0] words_done;

    logic        in_ready2, out_valid2, out_last2, busy2;
    logic [7:0]  out_byte2;
    logic [1:0]  words_done2;

    int checks = 0;
    int errors = 0;

    // model: remaining bytes of the held word as {last, byte}
    logic [8:0]  exp_q[$];
    int unsigned exp_cnt;
    bit          exp_ir;
    bit          obs_ir;

    always #5 clk = ~clk;

    word_byte_serializer #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len),
        .in_lsb_first(in_lsb_first),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last),
        .busy(busy), .words_done(words_done)
    );

    word_byte_serializer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_len(in_len),
        .in_lsb_first(in_lsb_first),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_byte(out_byte2), .out_last(out_last2),
        .busy(busy2), .words_done(words_done2)
    );

    function automatic logic [10:0] dut_o();
        return {out_valid, busy, out_last,
                out_valid ? out_byte : 8'h00};
    endfunction

    function automatic logic [10:0] mdl_o();
        if (exp_q.size() == 0) return 11'h0;
        return {2'b11, exp_q[0]};
    endfunction

    // drive one cycle, sample in_ready before the edge, advance the model
    task automatic tick(input bit rst, input bit v,
                        input logic [31:0] d, input logic [1:0] l,
                        input bit lsb, input bit ordy);
        reset = rst; in_valid = v; in_data = d;
        in_len = l; in_lsb_first = lsb; out_ready = ordy;
        #1;
        obs_ir = in_ready;
        exp_ir = !rst && (exp_q.size() == 0 ||
                          (ordy && exp_q.size() == 1));
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (ordy && exp_q.size() > 0) begin
                if (exp_q[0][8]) exp_cnt++;
                void'(exp_q.pop_front());
            end
            if (v && exp_ir) begin
                for (int k = 0; k <= int'(l); k++) begin
                    int lane;
                    lane = lsb ? 3 - k : k;
                    exp_q.push_back({k == int'(l),
                                     8'(d >> (8 * (3 - lane)))});
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 32'hDEADBEEF, 3, 0, 1);
        checks++;
        if (obs_ir !== 1'b0) begin
            errors++;
            $display("FAIL reset in_ready: got %b want 0", obs_ir);
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if ({out_valid, out_byte, out_last, busy} !== 11'h0) begin
            errors++;
            $display("FAIL reset outs: got v%b b%h l%b busy%b want 0",
                     out_valid, out_byte, out_last, busy);
        end
        checks++;
        if (words_done !== 16'd0 || words_done2 !== 2'd0) begin
            errors++;
            $display("FAIL reset count: got %0d/%0d want 0",
                     words_done, words_done2);
        end
    endtask

    task automatic test_directed();
        logic [31:0] wd[3] = '{32'h12345678, 32'h12345678, 32'hAABBCCDD};
        logic [1:0]  wl[3] = '{2'd3, 2'd3, 2'd1};
        bit          wo[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0]  eb[10] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                8'h78, 8'h56, 8'h34, 8'h12,
                                8'hAA, 8'hBB};
        int n = 0;
        tick(1, 0, 0, 0, 0, 0);
        for (int w = 0; w < 3; w++) begin
            tick(0, 1, wd[w], wl[w], wo[w], 1);
            for (int b = 0; b <= int'(wl[w]); b++) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== eb[n] ||
                    out_last !== (b == int'(wl[w]))) begin
                    errors++;
                    $display("FAIL directed byte%0d: got v%b %h l%b want %h l%b",
                             n, out_valid, out_byte, out_last, eb[n],
                             b == int'(wl[w]));
                end
                checks++;
                if (dut_o() !== mdl_o()) begin
                    errors++;
                    $display("FAIL directed model: got %h want %h",
                             dut_o(), mdl_o());
                end
                n++;
                tick(0, 0, 0, 0, 0, 1);
                checks++;
                if (obs_ir !== exp_ir) begin
                    errors++;
                    $display("FAIL directed in_ready: got %b want %b",
                             obs_ir, exp_ir);
                end
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 ||
                words_done !== 16'(w + 1)) begin
                errors++;
                $display("FAIL directed idle: got v%b busy%b cnt%0d want 0 0 %0d",
                         out_valid, busy, words_done, w + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wq[$];
        logic [7:0]  got[$];
        logic [8:0]  ir_mask = '0;
        tick(1, 0, 0, 0, 0, 0);
        wq.push_back(32'h01020304);
        wq.push_back(32'h05060708);
        for (int c = 0; c < 9; c++) begin
            bit v;
            v = wq.size() > 0;
            tick(0, v, v ? wq[0] : 32'h0, 3, 0, 1);
            if (v && obs_ir) void'(wq.pop_front());
            ir_mask[c] = obs_ir;
            checks++;
            if (obs_ir !== exp_ir || dut_o() !== mdl_o()) begin
                errors++;
                $display("FAIL b2b cycle%0d: got ir%b %h want ir%b %h",
                         c, obs_ir, dut_o(), exp_ir, mdl_o());
            end
            if (out_valid) got.push_back(out_byte);
        end
        checks++;
        if (ir_mask !== 9'b1_0001_0001) begin
            errors++;
            $display("FAIL b2b ready mask: got %b want 100010001", ir_mask);
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL b2b byte count: got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL b2b byte%0d: got %h want %h",
                             i, got[i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (words_done !== 16'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b end: got cnt%0d v%b want 2 0",
                     words_done, out_valid);
        end
    endtask

    task automatic test_stall();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 32'h12345678, 3, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        for (int s = 0; s < 3; s++) begin
            tick(0, 1, 32'hFFFFFFFF, 0, 1, 0);
            checks++;
            if (out_valid !== 1'b1 || out_byte !== 8'h34 ||
                out_last !== 1'b0 || obs_ir !== 1'b0) begin
                errors++;
                $display("FAIL stall hold%0d: got v%b %h l%b ir%b want 1 34 0 0",
                         s, out_valid, out_byte, out_last, obs_ir);
            end
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (out_byte !== 8'h56 || dut_o() !== mdl_o()) begin
            errors++;
            $display("FAIL stall resume: got %h want 56", out_byte);
        end
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (words_done !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall end: got cnt%0d v%b want 1 0",
                     words_done, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 32'h12345678, 3, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (out_byte !== 8'h56) begin
            errors++;
            $display("FAIL rstmid setup: got %h want 56", out_byte);
        end
        tick(1, 1, 32'h99999999, 3, 0, 1);
        checks++;
        if (obs_ir !== 1'b0) begin
            errors++;
            $display("FAIL rstmid in_ready: got %b want 0", obs_ir);
        end
        checks++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00 ||
            words_done !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid outs: got v%b %h cnt%0d busy%b want 0 00 0 0",
                     out_valid, out_byte, words_done, busy);
        end
        tick(0, 1, 32'hAABBCCDD, 3, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'hAA || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid restart: got v%b %h l%b want 1 AA 0",
                     out_valid, out_byte, out_last);
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (words_done !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid end: got cnt%0d v%b want 1 0",
                     words_done, out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] ew[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, $urandom, 0, $urandom_range(0, 1), 1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_last !== 1'b1 ||
                out_byte !== mdl_o()[7:0]) begin
                errors++;
                $display("FAIL wrap byte%0d: got v%b l%b %h want 1 1 %h",
                         i, out_valid, out_last, out_byte, mdl_o()[7:0]);
            end
            tick(0, i < 4, $urandom, 0, $urandom_range(0, 1), 1);
            checks++;
            if (words_done2 !== ew[i] || words_done !== 16'(i + 1)) begin
                errors++;
                $display("FAIL wrap count%0d: got %0d/%0d want %0d/%0d",
                         i, words_done2, words_done, ew[i], i + 1);
            end
        end
    endtask

    task automatic test_random();
        tick(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            tick($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                 $urandom, 2'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0);
            checks++;
            if (obs_ir !== exp_ir || dut_o() !== mdl_o() ||
                words_done !== 16'(exp_cnt) ||
                words_done2 !== 2'(exp_cnt)) begin
                errors++;
                $display("FAIL random cycle%0d: got ir%b %h cnt%0d/%0d want ir%b %h cnt%0d",
                         c, obs_ir, dut_o(), words_done, words_done2,
                         exp_ir, mdl_o(), exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
